// File: rtl/integration_arbiter.sv
// Two-port round-robin arbiter sharing one integration_file slave port.
// One transaction per grant; reads hold the grant until their data is returned.
//
//   state   | meaning
//   IDLE    | arbitrate between requesting ports, latch the winner's command
//   ISSUE   | drive the latched command downstream, accept it on the granted port
//   WAIT    | count down the slave read latency, capture readdata on the last cycle
//   RESP    | present captured read data to the granted port for one cycle
module integration_arbiter #(
  parameter int N      = 32,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              csi_clk,
  input  logic              rsi_rst,
  input  logic [ADDR_W-1:0] avs_p0_address,
  input  logic              avs_p0_write,
  input  logic [N-1:0]      avs_p0_writedata,
  input  logic              avs_p0_read,
  output logic [N-1:0]      avs_p0_readdata,
  output logic              avs_p0_readdatavalid,
  output logic              avs_p0_waitrequest,
  input  logic [ADDR_W-1:0] avs_p1_address,
  input  logic              avs_p1_write,
  input  logic [N-1:0]      avs_p1_writedata,
  input  logic              avs_p1_read,
  output logic [N-1:0]      avs_p1_readdata,
  output logic              avs_p1_readdatavalid,
  output logic              avs_p1_waitrequest,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [N-1:0]      avm_writedata,
  output logic              avm_read,
  input  logic [N-1:0]      avm_readdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  logic [1:0]        state;
  logic              last_grant;
  logic              gnt;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [N-1:0]      wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              req0;
  logic              req1;
  logic              pick;

  assign req0 = avs_p0_read | avs_p0_write;
  assign req1 = avs_p1_read | avs_p1_write;

  // Under contention the port that did not win last time goes next.
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last_grant;
  end

  always_ff @(posedge csi_clk or posedge rsi_rst) begin
    if (rsi_rst) begin
      state           <= S_IDLE;
      last_grant      <= 1'b1;
      gnt             <= 1'b0;
      op_write        <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      cnt             <= '0;
      avs_p0_readdata <= '0;
      avs_p1_readdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            gnt        <= pick;
            last_grant <= pick;
            addr_q     <= pick ? avs_p1_address   : avs_p0_address;
            wdata_q    <= pick ? avs_p1_writedata : avs_p0_writedata;
            op_write   <= pick ? avs_p1_write     : avs_p0_write;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (op_write) begin
            state <= S_IDLE;
          end else begin
            cnt   <= CNT_W'(RD_LAT);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            if (gnt) avs_p1_readdata <= avm_readdata;
            else     avs_p0_readdata <= avm_readdata;
            state <= S_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign avm_address          = addr_q;
  assign avm_writedata        = wdata_q;
  assign avm_write            = (state == S_ISSUE) &&  op_write;
  assign avm_read             = (state == S_ISSUE) && !op_write;
  assign avs_p0_waitrequest   = !((state == S_ISSUE) && !gnt);
  assign avs_p1_waitrequest   = !((state == S_ISSUE) &&  gnt);
  assign avs_p0_readdatavalid = (state == S_RESP) && !gnt;
  assign avs_p1_readdatavalid = (state == S_RESP) &&  gnt;

endmodule

// File: tb/tb_integration_arbiter.sv
// Bench for integration_arbiter: directed stimulus with a queue-based scoreboard
// checking every downstream issue and every read response, plus an accumulating slave model.
module tb_integration_arbiter;

  logic        csi_clk;
  logic        rsi_rst;
  logic [7:0]  p0_address, p1_address;
  logic        p0_write, p0_read, p1_write, p1_read;
  logic [31:0] p0_writedata, p1_writedata;
  logic [31:0] p0_readdata, p1_readdata;
  logic        p0_readdatavalid, p1_readdatavalid;
  logic        p0_waitrequest, p1_waitrequest;
  logic [7:0]  avm_address;
  logic        avm_write, avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  integration_arbiter #(.N(32), .ADDR_W(8), .RD_LAT(1)) dut (
    .csi_clk              (csi_clk),
    .rsi_rst              (rsi_rst),
    .avs_p0_address       (p0_address),
    .avs_p0_write         (p0_write),
    .avs_p0_writedata     (p0_writedata),
    .avs_p0_read          (p0_read),
    .avs_p0_readdata      (p0_readdata),
    .avs_p0_readdatavalid (p0_readdatavalid),
    .avs_p0_waitrequest   (p0_waitrequest),
    .avs_p1_address       (p1_address),
    .avs_p1_write         (p1_write),
    .avs_p1_writedata     (p1_writedata),
    .avs_p1_read          (p1_read),
    .avs_p1_readdata      (p1_readdata),
    .avs_p1_readdatavalid (p1_readdatavalid),
    .avs_p1_waitrequest   (p1_waitrequest),
    .avm_address          (avm_address),
    .avm_write            (avm_write),
    .avm_writedata        (avm_writedata),
    .avm_read             (avm_read),
    .avm_readdata         (avm_readdata)
  );

  initial begin
    csi_clk = 1'b0;
    forever #5 csi_clk = ~csi_clk;
  end

  // Slave: writes accumulate into the addressed word, reads return after one cycle.
  logic [31:0] mem [0:15];
  always_ff @(posedge csi_clk or posedge rsi_rst) begin
    if (rsi_rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      avm_readdata <= '0;
    end else begin
      if (avm_write) mem[avm_address[3:0]] <= mem[avm_address[3:0]] + avm_writedata;
      if (avm_read)  avm_readdata <= mem[avm_address[3:0]];
    end
  end

  typedef struct {int port; bit wr; logic [7:0] addr; logic [31:0] data;} iss_t;
  typedef struct {int port; logic [31:0] data;} rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic exp_issue(input int port, input bit wr, input logic [7:0] addr, input logic [31:0] data);
    iss_t e;
    e.port = port; e.wr = wr; e.addr = addr; e.data = data;
    iss_q.push_back(e);
  endtask

  task automatic exp_resp(input int port, input logic [31:0] data);
    rsp_t r;
    r.port = port; r.data = data;
    rsp_q.push_back(r);
  endtask

  iss_t m_iss;
  rsp_t m_rsp;
  int   m_port;

  always @(negedge csi_clk) begin
    if (!rsi_rst) begin
      if (avm_write || avm_read) begin
        m_port = !p0_waitrequest ? 0 : (!p1_waitrequest ? 1 : 2);
        if (iss_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_issue: port %0d wr %0b addr %0h", m_port, avm_write, avm_address);
        end else begin
          m_iss = iss_q.pop_front();
          check("issue_port",  m_port, m_iss.port);
          check("issue_write", {31'b0, avm_write}, {31'b0, m_iss.wr});
          check("issue_read",  {31'b0, avm_read},  {31'b0, !m_iss.wr});
          check("issue_addr",  {24'b0, avm_address}, {24'b0, m_iss.addr});
          if (m_iss.wr) check("issue_data", avm_writedata, m_iss.data);
        end
      end
      if (p0_readdatavalid || p1_readdatavalid) begin
        m_port = (p0_readdatavalid && p1_readdatavalid) ? 2 : (p1_readdatavalid ? 1 : 0);
        if (rsp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: port %0d", m_port);
        end else begin
          m_rsp = rsp_q.pop_front();
          check("resp_port", m_port, m_rsp.port);
          check("resp_data", m_port == 1 ? p1_readdata : p0_readdata, m_rsp.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge csi_clk); #1;
  endtask

  task automatic clear_reqs();
    p0_write = 0; p0_read = 0; p1_write = 0; p1_read = 0;
  endtask

  task automatic pulse_reset();
    rsi_rst = 1; step(); rsi_rst = 0; step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_p0_wait"},  {31'b0, p0_waitrequest}, 32'd1);
    check({tag, "_p1_wait"},  {31'b0, p1_waitrequest}, 32'd1);
    check({tag, "_avm_wr"},   {31'b0, avm_write}, 32'd0);
    check({tag, "_avm_rd"},   {31'b0, avm_read}, 32'd0);
    check({tag, "_avm_addr"}, {24'b0, avm_address}, 32'd0);
    check({tag, "_avm_wdat"}, avm_writedata, 32'd0);
    check({tag, "_p0_valid"}, {31'b0, p0_readdatavalid}, 32'd0);
    check({tag, "_p1_valid"}, {31'b0, p1_readdatavalid}, 32'd0);
    check({tag, "_p0_rdata"}, p0_readdata, 32'd0);
    check({tag, "_p1_rdata"}, p1_readdata, 32'd0);
  endtask

  // Holds each port's request until it has been accepted n times, then drops it.
  task automatic serve(input string nm, input int n0, input int n1);
    int c0 = 0;
    int c1 = 0;
    int cyc = 0;
    while ((c0 < n0 || c1 < n1) && cyc < 200) begin
      @(negedge csi_clk);
      cyc++;
      if (!p0_waitrequest) c0++;
      if (!p1_waitrequest) c1++;
      @(posedge csi_clk); #1;
      if (c0 >= n0) begin p0_write = 0; p0_read = 0; end
      if (c1 >= n1) begin p1_write = 0; p1_read = 0; end
    end
    check({nm, "_p0_accepts"}, c0, n0);
    check({nm, "_p1_accepts"}, c1, n1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rsi_rst = 1;
    clear_reqs();
    p0_address = 0; p1_address = 0; p0_writedata = 0; p1_writedata = 0;
    step(); step();
    check_reset_outputs("reset");
    rsi_rst = 0;
    step();

    // Test 1: lone p0 write, accepted and issued one cycle after request
    exp_issue(0, 1, 8'd0, 32'd55);
    p0_address = 8'd0; p0_writedata = 32'd55; p0_write = 1;
    step();
    check("t1_avm_write", {31'b0, avm_write}, 32'd1);
    check("t1_p0_wait",   {31'b0, p0_waitrequest}, 32'd0);
    check("t1_p1_wait",   {31'b0, p1_waitrequest}, 32'd1);
    p0_write = 0;
    step();

    // Test 2: p0 read of accumulated value, valid three cycles after request
    exp_issue(0, 0, 8'd0, 32'd0);
    exp_resp(0, 32'd55);
    p0_read = 1;
    step();
    check("t2_avm_read", {31'b0, avm_read}, 32'd1);
    p0_read = 0;
    step();
    check("t2_early_valid", {31'b0, p0_readdatavalid}, 32'd0);
    step();
    check("t2_p0_valid", {31'b0, p0_readdatavalid}, 32'd1);
    check("t2_p0_rdata", p0_readdata, 32'd55);
    check("t2_p1_valid", {31'b0, p1_readdatavalid}, 32'd0);
    step();
    check("t2_valid_one_cycle", {31'b0, p0_readdatavalid}, 32'd0);
    check("t2_rdata_hold", p0_readdata, 32'd55);

    // Test 3: continuous contention alternates strictly starting at p0
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      exp_issue(0, 1, 8'd1, 32'd11);
      exp_issue(1, 1, 8'd2, 32'd7);
    end
    p0_address = 8'd1; p0_writedata = 32'd11; p0_write = 1;
    p1_address = 8'd2; p1_writedata = 32'd7;  p1_write = 1;
    serve("t3", 3, 3);
    repeat (4) step();
    check("t3_issues_drained", iss_q.size(), 0);

    // Test 4: p0 write beats p1 read from reset; read sees the written value
    pulse_reset();
    exp_issue(0, 1, 8'd3, 32'd9);
    exp_issue(1, 0, 8'd3, 32'd0);
    exp_resp(1, 32'd9);
    p0_address = 8'd3; p0_writedata = 32'd9; p0_write = 1;
    p1_address = 8'd3; p1_read = 1;
    serve("t4", 1, 1);
    repeat (5) step();
    check("t4_p1_rdata", p1_readdata, 32'd9);

    // Test 5: reset during WAIT abandons the read
    exp_issue(0, 0, 8'd3, 32'd0);
    p0_address = 8'd3; p0_read = 1;
    step();
    p0_read = 0;
    step();
    rsi_rst = 1;
    #1;
    check_reset_outputs("t5_rst");
    step();
    check("t5_p0_valid_in_rst", {31'b0, p0_readdatavalid}, 32'd0);
    rsi_rst = 0;
    repeat (4) step();
    exp_issue(1, 1, 8'd4, 32'd5);
    p1_address = 8'd4; p1_writedata = 32'd5; p1_write = 1;
    serve("t5_after", 0, 1);
    repeat (3) step();

    // Test 6: read+write together is a write only; read back via p1
    exp_issue(0, 1, 8'd5, 32'd3);
    p0_address = 8'd5; p0_writedata = 32'd3; p0_write = 1; p0_read = 1;
    serve("t6", 1, 0);
    repeat (4) step();
    exp_issue(1, 0, 8'd5, 32'd0);
    exp_resp(1, 32'd3);
    p1_address = 8'd5; p1_read = 1;
    serve("t6_rb", 0, 1);
    repeat (5) step();

    check("final_issues_drained", iss_q.size(), 0);
    check("final_resps_drained",  rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
